// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types and constants for the master engine.
package axi4lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t      RespOkay    = 2'b00;
  localparam resp_t      RespSlverr  = 2'b10;
  localparam logic [2:0] ProtDefault = 3'b000;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrB,
    StRdA,
    StRdR,
    StResp,
    StDrain
  } state_e;

endpackage

// File: rtl/axi4lite_master_engine.sv
// Single-outstanding AXI4-Lite initiator: command/response port in, AW/W/B and AR/R out.
// All AXI outputs come straight from flops; a timed-out transaction is drained before the
// engine accepts another command.
module axi4lite_master_engine
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // command / response port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  // AXI4-Lite master
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  localparam int unsigned StrbW = DATA_W / 8;
  // Counter saturates at TIMEOUT_CYC-1, so clog2(TIMEOUT_CYC) bits suffice.
  localparam int unsigned CntW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d;
  logic                rready_q, rready_d;
  logic                is_write_q, is_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic busy, timeout_hit, enter_drain;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs;

  assign aw_hs  = awvalid_q & M_AXI_AWREADY;
  assign w_hs   = wvalid_q & M_AXI_WREADY;
  assign ar_hs  = arvalid_q & M_AXI_ARREADY;
  assign b_hs   = bready_q & M_AXI_BVALID;
  assign r_hs   = rready_q & M_AXI_RVALID;
  assign rsp_hs = rsp_valid_q & rsp_ready;

  assign busy = (state_q == StWr) || (state_q == StWrB) ||
                (state_q == StRdA) || (state_q == StRdR);
  // Fires after TIMEOUT_CYC cycles spent waiting on the bus.
  assign timeout_hit = (TIMEOUT_CYC != 0) && busy && (cnt_q == CntLast);

  // Next-state and output-register logic.
  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    is_write_d    = is_write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = (busy && (cnt_q != CntLast)) ? cnt_q + CntW'(1) : cnt_q;
    enter_drain   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          is_write_d    = cmd_write;
          addr_d        = cmd_addr;
          wdata_d       = cmd_wdata;
          wstrb_d       = cmd_wstrb;
          cnt_d         = '0;
          rsp_rdata_d   = '0;
          rsp_resp_d    = RespOkay;
          rsp_timeout_d = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWr;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdA;
          end
        end
      end
      StWr: begin
        // AW and W retire independently; each VALID drops after its own handshake.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = StWrB;
        end else if (timeout_hit) begin
          enter_drain = 1'b1;
        end
      end
      StWrB: begin
        // A response arriving on the timeout cycle still counts as completion.
        if (b_hs) begin
          rsp_resp_d  = M_AXI_BRESP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (timeout_hit) begin
          enter_drain = 1'b1;
        end
      end
      StRdA: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdR;
        end else if (timeout_hit) begin
          enter_drain = 1'b1;
        end
      end
      StRdR: begin
        if (r_hs) begin
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (timeout_hit) begin
          enter_drain = 1'b1;
        end
      end
      StResp: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StDrain: begin
        // Finish every open channel, discarding any late response data.
        if (aw_hs)  awvalid_d   = 1'b0;
        if (w_hs)   wvalid_d    = 1'b0;
        if (ar_hs)  arvalid_d   = 1'b0;
        if (b_hs)   bready_d    = 1'b0;
        if (r_hs)   rready_d    = 1'b0;
        if (rsp_hs) rsp_valid_d = 1'b0;
        if (!(awvalid_d || wvalid_d || arvalid_d || bready_d || rready_d || rsp_valid_d)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_drain) begin
      state_d       = StDrain;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = RespSlverr;
      rsp_rdata_d   = '0;
      bready_d      = is_write_q;
      rready_d      = ~is_write_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= StIdle;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      is_write_q    <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RespOkay;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      is_write_q    <= is_write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = ProtDefault;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = ProtDefault;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
